// File: rtl/async_receiver.sv
// ---------------------------------------------------------------------------
// async_receiver : UART 8N1 receiver, oversampled, majority-filtered, mid-bit
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module async_receiver #(
  parameter int ClkFrequency = 50000000,
  parameter int Baud         = 115200,
  parameter int Oversampling = 8,
  parameter int IdleBits     = 10
) (
  input  logic       CLOCK_50,
  input  logic       rst,
  input  logic       UART_RXD,
  output logic [7:0] RxD_data,
  output logic       RxD_data_ready,
  output logic       RxD_frame_err,
  output logic       RxD_idle,
  output logic       RxD_endofpacket
);

  localparam int ACC_WIDTH = 16;
  localparam logic [63:0] ACC_INC_W =
      (((64'(Baud) * 64'(Oversampling)) << ACC_WIDTH) + 64'(ClkFrequency / 2)) / 64'(ClkFrequency);
  localparam logic [ACC_WIDTH-1:0] ACC_INC = ACC_WIDTH'(ACC_INC_W);

  localparam int OS_W = $clog2(Oversampling);
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(Oversampling - 1);
  localparam logic [OS_W-1:0] OS_HALF = OS_W'(Oversampling / 2 - 1);
  localparam logic [OS_W-1:0] OS_ONE  = OS_W'(1);

  localparam int GAP_MAX = IdleBits * Oversampling;
  localparam int GAP_W   = $clog2(GAP_MAX + 1);
  localparam logic [GAP_W-1:0] GAP_SAT = GAP_W'(GAP_MAX);
  localparam logic [GAP_W-1:0] GAP_ONE = GAP_W'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  logic [ACC_WIDTH:0] acc;
  logic               tick;
  logic [1:0]         sync;
  logic [2:0]         hist;
  logic               rx_bit;
  state_t             state;
  logic [OS_W-1:0]    os_cnt;
  logic [2:0]         bit_idx;
  logic [7:0]         shift_reg;
  logic [GAP_W-1:0]   gap_cnt;
  logic               stop_seen;

  // Tick is the carry of a free-running fractional accumulator.
  assign tick   = acc[ACC_WIDTH];
  assign rx_bit = (hist[0] & hist[1]) | (hist[0] & hist[2]) | (hist[1] & hist[2]);

  always_ff @(posedge CLOCK_50 or negedge rst) begin
    if (!rst) begin
      acc  <= '0;
      sync <= 2'b11;
      hist <= 3'b111;
    end else begin
      acc  <= {1'b0, acc[ACC_WIDTH-1:0]} + {1'b0, ACC_INC};
      sync <= {sync[0], UART_RXD};
      if (tick) hist <= {hist[1:0], sync[1]};
    end
  end

  always_ff @(posedge CLOCK_50 or negedge rst) begin
    if (!rst) begin
      state           <= S_IDLE;
      os_cnt          <= '0;
      bit_idx         <= '0;
      shift_reg       <= '0;
      gap_cnt         <= '0;
      stop_seen       <= 1'b0;
      RxD_data        <= '0;
      RxD_data_ready  <= 1'b0;
      RxD_frame_err   <= 1'b0;
      RxD_idle        <= 1'b0;
      RxD_endofpacket <= 1'b0;
    end else begin
      RxD_data_ready  <= 1'b0;
      RxD_frame_err   <= 1'b0;
      RxD_endofpacket <= 1'b0;
      if (tick) begin
        case (state)
          S_IDLE: begin
            if (!rx_bit) begin
              state    <= S_START;
              os_cnt   <= '0;
              gap_cnt  <= '0;
              RxD_idle <= 1'b0;
            end else if (gap_cnt != GAP_SAT) begin
              gap_cnt <= gap_cnt + GAP_ONE;
            end
          end
          S_START: begin
            if (os_cnt == OS_HALF) begin
              if (rx_bit) begin
                state <= S_IDLE;
              end else begin
                os_cnt  <= '0;
                bit_idx <= '0;
                state   <= S_DATA;
              end
            end else begin
              os_cnt <= os_cnt + OS_ONE;
            end
          end
          S_DATA: begin
            if (os_cnt == OS_LAST) begin
              os_cnt    <= '0;
              shift_reg <= {rx_bit, shift_reg[7:1]};
              if (bit_idx == 3'd7) state <= S_STOP;
              else bit_idx <= bit_idx + 3'd1;
            end else begin
              os_cnt <= os_cnt + OS_ONE;
            end
          end
          S_STOP: begin
            if (os_cnt == OS_LAST) begin
              os_cnt    <= '0;
              stop_seen <= 1'b1;
              if (rx_bit) begin
                RxD_data       <= shift_reg;
                RxD_data_ready <= 1'b1;
                state          <= S_IDLE;
              end else begin
                RxD_frame_err <= 1'b1;
                state         <= S_BREAK;
              end
            end else begin
              os_cnt <= os_cnt + OS_ONE;
            end
          end
          S_BREAK: begin
            if (rx_bit) state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
      // Idle needs a measured gap that follows at least one stop bit.
      if (state == S_IDLE && rx_bit && gap_cnt == GAP_SAT && stop_seen && !RxD_idle) begin
        RxD_idle        <= 1'b1;
        RxD_endofpacket <= 1'b1;
        stop_seen       <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_async_receiver.sv
// ---------------------------------------------------------------------------
// tb_async_receiver : directed scoreboard bench for async_receiver
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_async_receiver;

  localparam int BIT = 434;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       UART_RXD = 1'b1;
  logic [7:0] RxD_data;
  logic       RxD_data_ready;
  logic       RxD_frame_err;
  logic       RxD_idle;
  logic       RxD_endofpacket;

  async_receiver dut (
    .CLOCK_50        (clk),
    .rst             (rst),
    .UART_RXD        (UART_RXD),
    .RxD_data        (RxD_data),
    .RxD_data_ready  (RxD_data_ready),
    .RxD_frame_err   (RxD_frame_err),
    .RxD_idle        (RxD_idle),
    .RxD_endofpacket (RxD_endofpacket)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Output collection: bytes into a queue, strobes and idle edges into counters.
  logic [7:0] got_q[$];
  int ready_cnt = 0, ferr_cnt = 0, eop_cnt = 0, overlap_cnt = 0;
  int rise_cnt = 0, fall_cnt = 0, rise_cyc = 0, fall_cyc = 0;
  logic idle_q = 1'b0;

  always @(negedge clk) begin
    if (RxD_data_ready) begin
      ready_cnt <= ready_cnt + 1;
      got_q.push_back(RxD_data);
    end
    if (RxD_frame_err)   ferr_cnt <= ferr_cnt + 1;
    if (RxD_endofpacket) eop_cnt  <= eop_cnt + 1;
    if (int'(RxD_data_ready) + int'(RxD_frame_err) + int'(RxD_endofpacket) > 1)
      overlap_cnt <= overlap_cnt + 1;
    if (RxD_idle && !idle_q) begin
      rise_cnt <= rise_cnt + 1;
      rise_cyc <= cyc;
    end
    if (!RxD_idle && idle_q) begin
      fall_cnt <= fall_cnt + 1;
      fall_cyc <= cyc;
    end
    idle_q <= RxD_idle;
  end

  logic [7:0] exp_q[$];
  int vectors = 0, fails = 0;
  int r0, f0, e0, i0, t0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drain();
    logic [31:0] want;
    while (got_q.size() > 0) begin
      if (exp_q.size() > 0) want = {24'h0, exp_q.pop_front()};
      else want = 32'hFFFF_FFFF;
      check("rx_byte", {24'h0, got_q.pop_front()}, want);
    end
    check("pending_bytes", exp_q.size(), 0);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Line is left at the stop-bit level on return.
  task automatic send(input logic [7:0] b, input logic stop);
    UART_RXD = 1'b0;
    wait_clk(BIT);
    for (int i = 0; i < 8; i++) begin
      UART_RXD = b[i];
      wait_clk(BIT);
    end
    UART_RXD = stop;
    wait_clk(BIT);
  endtask

  initial begin
    logic [7:0] partial;
    partial = 8'h99;

    wait_clk(5);
    check("rst_data",  RxD_data, 0);
    check("rst_ready", RxD_data_ready, 0);
    check("rst_ferr",  RxD_frame_err, 0);
    check("rst_idle",  RxD_idle, 0);
    check("rst_eop",   RxD_endofpacket, 0);
    rst = 1'b1;
    wait_clk(11 * BIT);
    check("idle_without_stop", RxD_idle, 0);

    // Plain frame
    r0 = ready_cnt; f0 = ferr_cnt;
    exp_q.push_back(8'hA5);
    send(8'hA5, 1'b1);
    wait_clk(BIT);
    drain();
    check("a5_ready_pulses", ready_cnt - r0, 1);
    check("a5_ferr", ferr_cnt - f0, 0);
    check("a5_data", RxD_data, 8'hA5);

    // Short glitch must be rejected
    r0 = ready_cnt; f0 = ferr_cnt;
    UART_RXD = 1'b0;
    wait_clk(100);
    UART_RXD = 1'b1;
    wait_clk(2 * BIT);
    check("glitch_ready", ready_cnt - r0, 0);
    check("glitch_ferr", ferr_cnt - f0, 0);

    // Framing error, then recovery
    r0 = ready_cnt; f0 = ferr_cnt;
    send(8'h3C, 1'b0);
    wait_clk(2 * BIT);
    UART_RXD = 1'b1;
    wait_clk(BIT);
    check("ferr_pulses", ferr_cnt - f0, 1);
    check("ferr_ready", ready_cnt - r0, 0);
    check("ferr_data_hold", RxD_data, 8'hA5);
    exp_q.push_back(8'h5A);
    send(8'h5A, 1'b1);
    wait_clk(BIT);
    drain();
    check("after_ferr_data", RxD_data, 8'h5A);

    // Back-to-back frames
    r0 = ready_cnt;
    exp_q.push_back(8'h00);
    send(8'h00, 1'b1);
    exp_q.push_back(8'hFF);
    send(8'hFF, 1'b1);
    exp_q.push_back(8'h81);
    send(8'h81, 1'b1);
    wait_clk(BIT);
    drain();
    check("b2b_ready_pulses", ready_cnt - r0, 3);
    check("b2b_last_data", RxD_data, 8'h81);

    // Reset in the middle of bit 4
    r0 = ready_cnt; f0 = ferr_cnt;
    UART_RXD = 1'b0;
    wait_clk(BIT);
    for (int i = 0; i < 4; i++) begin
      UART_RXD = partial[i];
      wait_clk(BIT);
    end
    UART_RXD = partial[4];
    wait_clk(BIT / 2);
    rst = 1'b0;
    UART_RXD = 1'b1;
    wait_clk(20);
    check("midrst_data",  RxD_data, 0);
    check("midrst_ready", RxD_data_ready, 0);
    check("midrst_ferr",  RxD_frame_err, 0);
    check("midrst_idle",  RxD_idle, 0);
    check("midrst_eop",   RxD_endofpacket, 0);
    rst = 1'b1;
    wait_clk(2 * BIT);
    check("midrst_no_strobe", (ready_cnt - r0) + (ferr_cnt - f0), 0);
    check("midrst_data_after", RxD_data, 0);
    exp_q.push_back(8'h42);
    send(8'h42, 1'b1);
    wait_clk(BIT);
    drain();
    check("after_rst_data", RxD_data, 8'h42);

    // Idle detection and end-of-packet
    exp_q.push_back(8'h11);
    send(8'h11, 1'b1);
    t0 = cyc; e0 = eop_cnt; i0 = rise_cnt;
    wait_clk(11 * BIT);
    drain();
    check("idle_rise_count", rise_cnt - i0, 1);
    check("eop_pulses", eop_cnt - e0, 1);
    check("idle_level", RxD_idle, 1);
    check("idle_delay_window", ((rise_cyc - t0) >= 4100) && ((rise_cyc - t0) <= 4400), 1);
    i0 = fall_cnt; t0 = cyc;
    exp_q.push_back(8'h22);
    send(8'h22, 1'b1);
    wait_clk(BIT);
    drain();
    check("idle_fall_count", fall_cnt - i0, 1);
    check("idle_fall_delay", ((fall_cyc - t0) >= 50) && ((fall_cyc - t0) <= 300), 1);
    check("idle_low_after_frame", RxD_idle, 0);
    check("strobe_overlap", overlap_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/async_receiver.md
Name: async_receiver

Overview:
- UART 8N1 receiver. It is the receive-side counterpart of the board's async transmitter and recovers bytes from the UART_RXD pin.
- The serial input is synchronised, oversampled, majority-filtered and sampled at mid-bit.
- Each valid byte is presented on RxD_data with a one-cycle strobe. Framing errors, line idle and end-of-packet are also flagged.
- It sits beside the transmitter in the top-level UART path and runs in the CLOCK_50 domain.

Parameters:
- ClkFrequency, 50000000, system clock frequency in Hz.
- Baud, 115200, line bit rate.
- Oversampling, 8, sample ticks per bit. Power of two, minimum 4.
- IdleBits, 10, bit times of continuous high line after a stop bit before idle is declared.

Ports:
- CLOCK_50  in  1  system clock; all logic is on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- UART_RXD  in  1  serial line, asynchronous, idles high.
- RxD_data  out  8  last correctly received byte, LSB first on the wire.
- RxD_data_ready  out  1  one-cycle pulse when RxD_data is updated.
- RxD_frame_err  out  1  one-cycle pulse when the stop bit samples low.
- RxD_idle  out  1  high while the line has been idle for at least IdleBits bit times.
- RxD_endofpacket  out  1  one-cycle pulse on the rising edge of RxD_idle.

Behaviour:
- Reset, asynchronous and active-low:
  - state = IDLE, sync and filter registers = 1, counters = 0, RxD_data = 8'h00.
  - RxD_data_ready, RxD_frame_err and RxD_endofpacket = 0.
  - RxD_idle = 0. It is not asserted until a gap is measured after reset.
  - Reset mid-frame abandons the byte with no strobe.
- Tick generator:
  - Internal fractional accumulator producing a one-clock tick at Baud*Oversampling.
  - Accumulator increments by round(Baud*Oversampling*2^AccWidth/ClkFrequency), with AccWidth = 16.
  - Tick = carry out. Free-running and never gated.
- Synchroniser: 2 flops on UART_RXD, both reset to 1.
- Filter:
  - On each tick, shift the synchronised bit into a 3-bit history.
  - rx_bit = majority of the 3 bits.
- State machine (advances only on tick):
  - IDLE: rx_bit==0 → START, os_cnt = 0.
  - START: os_cnt increments each tick. At os_cnt == Oversampling/2-1:
    - rx_bit==1 → IDLE (glitch rejected, no flag).
    - otherwise os_cnt = 0, bit_idx = 0 → DATA.
  - DATA:
    - os_cnt increments. At os_cnt == Oversampling-1, os_cnt = 0 and rx_bit shifts into shift_reg[7] (right shift).
    - After bit_idx 7 → STOP.
  - STOP: at os_cnt == Oversampling-1, sample rx_bit.
    - 1 → RxD_data = shift_reg, RxD_data_ready pulses for exactly one CLOCK_50 cycle, → IDLE.
    - 0 → RxD_frame_err pulses one cycle, RxD_data unchanged, → BREAK.
  - BREAK: stay until rx_bit==1, then → IDLE.
- Latency: RxD_data_ready asserts in the cycle after the mid-stop-bit tick, about 9.5 bit times after the falling start edge plus 3 synchroniser/filter ticks.
- A new start bit detected in the IDLE tick immediately after STOP is accepted, so back-to-back frames with no gap are supported.
- Gap counter:
  - Counts ticks while state==IDLE and rx_bit==1. Reset to 0 on any START entry.
  - Saturates at IdleBits*Oversampling.
  - RxD_idle = (gap counter saturated) AND at least one stop bit (good or bad) seen since the last saturation or reset.
  - RxD_endofpacket = one-cycle pulse when RxD_idle goes 0→1.
  - RxD_idle drops in the same cycle START is entered.
- Strobes never assert simultaneously. RxD_data holds between strobes.

Test Plan:
All scenarios use defaults; bit period = 434 clocks.
1. Send 0xA5 with an 8N1 frame → one RxD_data_ready pulse, RxD_data = 8'hA5, RxD_frame_err stays 0.
2. Drive UART_RXD low for 100 clocks, then high → no RxD_data_ready and no RxD_frame_err; state returns to IDLE.
3. Send 0x3C with the stop bit held low, release high 2 bit times later → RxD_frame_err pulses once, RxD_data keeps its previous value, the next frame 0x5A is received correctly.
4. Send 0x00, 0xFF, 0x81 back-to-back with no gap → three ready pulses with data 8'h00, 8'hFF, 8'h81 in order.
5. Hold rst low for 20 clocks in the middle of bit 4 of a frame, then release with the line high → no strobe; all outputs 0; the next full frame 0x42 is received.
6. After frame 0x11, hold the line high for 11 bit times → RxD_idle rises about 10 bit times after the stop sample, RxD_endofpacket pulses once, and RxD_idle falls when the next start bit is detected.
